bit_serializer_tx: RTL and testbench



---
 rtl/bit_serializer_tx_if.sv | 38 +++
 rtl/bit_serializer_tx.sv | 127 ++++++++++++
 tb/tb_bit_serializer_tx.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/bit_serializer_tx_if.sv
// ---------------------------------------------------------------------------
// bit_serializer_tx_if
// Purpose : bundles the word-side and bit-side handshakes of the
//           bit_serializer_tx so producer, consumer and serializer share one
//           set of wires.
// Signals :
//   din        - parallel word offered by the producer
//   din_valid  - producer has a word on din
//   din_ready  - serializer accepts the word this cycle
//   sout       - current serial bit
//   sout_valid - sout holds a valid bit
//   sout_ready - consumer takes sout this cycle
//   sout_last  - sout is the final bit of its word
// Modports:
//   slave  - the serializer's view (takes words, emits bits)
//   master - the environment's view (producer + consumer)
// ---------------------------------------------------------------------------
interface bit_serializer_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             sout_ready;
  logic             sout_last;

  modport slave (
    input  din, din_valid, sout_ready,
    output din_ready, sout, sout_valid, sout_last
  );

  modport master (
    output din, din_valid, sout_ready,
    input  din_ready, sout, sout_valid, sout_last
  );
endinterface

// File: rtl/bit_serializer_tx.sv
// ---------------------------------------------------------------------------
// bit_serializer_tx
// Purpose : parallel-to-serial transmitter. Takes one WIDTH-bit word over a
//           valid/ready handshake and shifts it out one bit per accepted
//           beat. With LSB_FIRST=1 the stream is the bit-reversed word read
//           MSB-first.
// Ports   :
//   clk         - rising-edge clock
//   rst_n       - asynchronous active-low reset
//   bus         - slave modport: din/din_valid/din_ready on the word side,
//                 sout/sout_valid/sout_ready/sout_last on the bit side
//   o_busy      - a word is in flight (state SHIFT)
//   o_dbg_state - FSM state (0 = IDLE, 1 = SHIFT)
//   o_dbg_cnt   - index of the bit currently presented on sout
//
// Handshake semantics (both sides): a transfer happens at a rising edge
// where valid && ready are both high. A source holding valid may not drop
// or change its data until the transfer; ready may depend combinationally
// on the other side's ready but never on the same side's valid.
// ---------------------------------------------------------------------------
module bit_serializer_tx #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  bit_serializer_tx_if.slave       bus,
  output logic                     o_busy,
  output logic                     o_dbg_state,
  output logic [$clog2(WIDTH)-1:0] o_dbg_cnt
);

  localparam int              CW     = $clog2(WIDTH);
  localparam logic [CW-1:0]   C_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;

  logic             w_sout_valid;
  logic             w_sout_last;
  logic             w_consume;
  logic             w_din_ready;
  logic             w_accept;

  // All bit-side outputs come straight from registered state.
  assign w_sout_valid = (r_state == S_SHIFT);
  assign w_sout_last  = w_sout_valid && (r_cnt == C_LAST);
  assign w_consume    = w_sout_valid && bus.sout_ready;

  // Ready again in the cycle the final bit leaves, so back-to-back words
  // keep sout_valid high with no bubble.
  assign w_din_ready  = (r_state == S_IDLE) || (w_consume && w_sout_last);
  assign w_accept     = bus.din_valid && w_din_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_shift_nxt = bus.din;
          w_cnt_nxt   = '0;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_consume) begin
          if (w_sout_last) begin
            if (w_accept) begin
              w_shift_nxt = bus.din;
              w_cnt_nxt   = '0;
            end else begin
              // Clear so sout reads 0 while idle.
              w_shift_nxt = '0;
              w_cnt_nxt   = '0;
              w_state_nxt = S_IDLE;
            end
          end else begin
            if (LSB_FIRST) begin
              w_shift_nxt = r_shift >> 1;
            end else begin
              w_shift_nxt = r_shift << 1;
            end
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_shift_nxt = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign bus.sout       = LSB_FIRST ? r_shift[0] : r_shift[WIDTH-1];
  assign bus.sout_valid = w_sout_valid;
  assign bus.sout_last  = w_sout_last;
  assign bus.din_ready  = w_din_ready;

  assign o_busy      = (r_state == S_SHIFT);
  assign o_dbg_state = r_state;
  assign o_dbg_cnt   = r_cnt;

endmodule

// File: tb/tb_bit_serializer_tx.sv
// ---------------------------------------------------------------------------
// tb_bit_serializer_tx
// Drives two serializers side by side (LSB_FIRST=1 and LSB_FIRST=0) and
// compares them every cycle against a bit-queue model: an accepted word
// becomes WIDTH queued bits in send order, a consumed beat pops the head.
// Directed scenarios also compare the collected stream with fixed words.
// ---------------------------------------------------------------------------
module tb_bit_serializer_tx;

  localparam int W  = 8;
  localparam int CW = $clog2(W);

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  bit_serializer_tx_if #(.WIDTH(W)) if_l ();
  bit_serializer_tx_if #(.WIDTH(W)) if_m ();

  logic          busy_l, busy_m;
  logic          st_l, st_m;
  logic [CW-1:0] cnt_l, cnt_m;

  bit_serializer_tx #(.WIDTH(W), .LSB_FIRST(1'b1)) u_dut_lsb (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (if_l.slave),
    .o_busy      (busy_l),
    .o_dbg_state (st_l),
    .o_dbg_cnt   (cnt_l)
  );

  bit_serializer_tx #(.WIDTH(W), .LSB_FIRST(1'b0)) u_dut_msb (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (if_m.slave),
    .o_busy      (busy_m),
    .o_dbg_state (st_m),
    .o_dbg_cnt   (cnt_m)
  );

  // ---------------- scoreboard ----------------
  int n_chk = 0;
  int n_err = 0;
  logic exp_q_l[$];
  logic exp_q_m[$];
  logic [31:0] col_l, col_m;
  int vcnt_l, vcnt_m;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Word -> bits in the order they must appear on the wire.
  task automatic push_word(inout logic q[$], input logic [W-1:0] d, input bit lsb);
    for (int i = 0; i < W; i++) q.push_back(lsb ? d[i] : d[W-1-i]);
  endtask

  task automatic chk_outputs(input string pfx, input logic q[$],
                             input logic sv, input logic so, input logic sl,
                             input logic bz, input logic [CW-1:0] cn);
    int sz;
    sz = q.size();
    chk_eq({pfx, "_sout_valid"}, 32'(sv), 32'(sz > 0));
    chk_eq({pfx, "_sout"},       32'(so), (sz > 0) ? 32'(q[0]) : 32'd0);
    chk_eq({pfx, "_sout_last"},  32'(sl), 32'(sz == 1));
    chk_eq({pfx, "_busy"},       32'(bz), 32'(sz > 0));
    chk_eq({pfx, "_cnt"},        32'(cn), (sz > 0) ? 32'(W - sz) : 32'd0);
  endtask

  // ---------------- driver ----------------
  // Entered just after a falling edge; leaves just after the next one.
  task automatic cycle(input logic [W-1:0] dl, input logic vl, input logic rl,
                       input logic [W-1:0] dm, input logic vm, input logic rm);
    logic rdy_l, rdy_m;
    chk_outputs("lsb", exp_q_l, if_l.sout_valid, if_l.sout, if_l.sout_last, busy_l, cnt_l);
    chk_outputs("msb", exp_q_m, if_m.sout_valid, if_m.sout, if_m.sout_last, busy_m, cnt_m);
    if_l.din = dl; if_l.din_valid = vl; if_l.sout_ready = rl;
    if_m.din = dm; if_m.din_valid = vm; if_m.sout_ready = rm;
    #1;
    rdy_l = (exp_q_l.size() == 0) || (exp_q_l.size() == 1 && rl);
    rdy_m = (exp_q_m.size() == 0) || (exp_q_m.size() == 1 && rm);
    chk_eq("lsb_din_ready", 32'(if_l.din_ready), 32'(rdy_l));
    chk_eq("msb_din_ready", 32'(if_m.din_ready), 32'(rdy_m));
    if (if_l.sout_valid) vcnt_l++;
    if (if_m.sout_valid) vcnt_m++;
    if (if_l.sout_valid && rl) col_l = {col_l[30:0], if_l.sout};
    if (if_m.sout_valid && rm) col_m = {col_m[30:0], if_m.sout};
    if (exp_q_l.size() > 0 && rl) void'(exp_q_l.pop_front());
    if (exp_q_m.size() > 0 && rm) void'(exp_q_m.pop_front());
    if (vl && rdy_l) push_word(exp_q_l, dl, 1'b1);
    if (vm && rdy_m) push_word(exp_q_m, dm, 1'b0);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Same stimulus to both instances.
  task automatic cyc2(input logic [W-1:0] d, input logic v, input logic r);
    cycle(d, v, r, d, v, r);
  endtask

  task automatic clear_obs();
    col_l = '0; col_m = '0; vcnt_l = 0; vcnt_m = 0;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk_eq({pfx, "_lsb_sout"},       32'(if_l.sout),       32'd0);
    chk_eq({pfx, "_lsb_sout_valid"}, 32'(if_l.sout_valid), 32'd0);
    chk_eq({pfx, "_lsb_sout_last"},  32'(if_l.sout_last),  32'd0);
    chk_eq({pfx, "_lsb_busy"},       32'(busy_l),          32'd0);
    chk_eq({pfx, "_lsb_din_ready"},  32'(if_l.din_ready),  32'd1);
    chk_eq({pfx, "_msb_sout"},       32'(if_m.sout),       32'd0);
    chk_eq({pfx, "_msb_sout_valid"}, 32'(if_m.sout_valid), 32'd0);
    chk_eq({pfx, "_msb_sout_last"},  32'(if_m.sout_last),  32'd0);
    chk_eq({pfx, "_msb_busy"},       32'(busy_m),          32'd0);
    chk_eq({pfx, "_msb_din_ready"},  32'(if_m.din_ready),  32'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    if_l.din = '0; if_l.din_valid = 1'b0; if_l.sout_ready = 1'b1;
    if_m.din = '0; if_m.din_valid = 1'b0; if_m.sout_ready = 1'b1;
    clear_obs();

    // 1: reset asserted between clock edges takes effect at once
    #3 rst_n = 1'b0;
    #1 chk_reset_outputs("rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 2: single word, full-rate consumer
    clear_obs();
    cyc2(8'hB4, 1'b1, 1'b1);
    repeat (9) cyc2(8'h00, 1'b0, 1'b1);
    chk_eq("t2_lsb_word", col_l & 32'hFF, 32'h2D);
    chk_eq("t2_msb_word", col_m & 32'hFF, 32'hB4);
    chk_eq("t2_valid_cycles", 32'(vcnt_l), 32'd8);

    // 3: back-to-back words, din_valid held high
    clear_obs();
    cyc2(8'hB4, 1'b1, 1'b1);
    repeat (8) cyc2(8'h0F, 1'b1, 1'b1);
    repeat (9) cyc2(8'h00, 1'b0, 1'b1);
    chk_eq("t3_lsb_stream", col_l & 32'hFFFF, 32'h2DF0);
    chk_eq("t3_msb_stream", col_m & 32'hFFFF, 32'hB40F);
    chk_eq("t3_valid_cycles", 32'(vcnt_l), 32'd16);

    // 4: consumer stalls 3 cycles on the 4th bit
    clear_obs();
    cyc2(8'hB4, 1'b1, 1'b1);
    repeat (3) cyc2(8'h00, 1'b0, 1'b1);
    repeat (3) cyc2(8'h5A, 1'b1, 1'b0);
    repeat (6) cyc2(8'h00, 1'b0, 1'b1);
    chk_eq("t4_lsb_word", col_l & 32'hFF, 32'h2D);
    chk_eq("t4_msb_word", col_m & 32'hFF, 32'hB4);
    chk_eq("t4_valid_cycles", 32'(vcnt_l), 32'd11);

    // 6: reset in the middle of a word
    clear_obs();
    cyc2(8'hB4, 1'b1, 1'b1);
    repeat (4) cyc2(8'h00, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    exp_q_l.delete();
    exp_q_m.delete();
    @(negedge clk);
    rst_n = 1'b1;
    clear_obs();
    cyc2(8'hFF, 1'b1, 1'b1);
    repeat (9) cyc2(8'h00, 1'b0, 1'b1);
    chk_eq("t6_lsb_word", col_l, 32'hFF);
    chk_eq("t6_msb_word", col_m, 32'hFF);

    // random traffic on both instances
    for (int i = 0; i < 600; i++) begin
      cycle(W'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
            W'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    end
    repeat (3 * W) cyc2(8'h00, 1'b0, 1'b1);
    chk_eq("drain_lsb", 32'(exp_q_l.size()), 32'd0);
    chk_eq("drain_msb", 32'(exp_q_m.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
